digit_roi_sampler: RTL

Fetch-and-binarize stage between the camera frame buffer and the digit-classifier NN. On a start pulse it walks a 28×28 grid of sample points inside the 320×240 RGB444 frame, reading the frame buffer's read port. Each sample is reduced to a 1-bit ink/background pixel and stored in an internal 784-bit image. The NN reads that image through a BRAM-like 1-bit port, so it never addresses the frame buffer directly and never sees a partially updated image.

---
 rtl/digit_roi_sampler.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/digit_roi_sampler.sv
// Purpose : on start, samples a 28x28 grid out of the RGB444 frame buffer and binarizes each sample
//           into a 1-bit image. The committed image is served to the NN through a registered 1-bit port.
// Latency : capture busy for 785+RD_LAT cycles after start; nn_data valid 1 cycle after nn_addr.
// Backpressure: none; start is only honoured in IDLE and is dropped otherwise (no queuing).
//
// Ports:
//   clk, reset_n         single clock, asynchronous active-low reset
//   start                one-cycle capture request
//   threshold, invert    binarization controls, held stable by the host while busy
//   fb_addr / fb_data    frame-buffer read port (fb_data returns RD_LAT cycles after fb_addr)
//   busy, done           capture in progress / one-cycle completion pulse
//   image_valid          sticky flag: at least one image has been committed
//   dark_count           number of 1-pixels in the committed image
//   nn_addr / nn_data    row-major pixel read port for the classifier

module digit_roi_sampler #(
    parameter int FRAME_W = 320,
    parameter int IMG_DIM = 28,
    parameter int STRIDE  = 8,
    parameter int X0      = 48,
    parameter int Y0      = 8,
    parameter int RD_LAT  = 1,
    parameter int FB_AW   = 17
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [5:0]       threshold,
    input  logic             invert,
    output logic [FB_AW-1:0] fb_addr,
    input  logic [11:0]      fb_data,
    output logic             busy,
    output logic             done,
    output logic             image_valid,
    output logic [9:0]       dark_count,
    input  logic [15:0]      nn_addr,
    output logic             nn_data
);

    localparam int NPIX = IMG_DIM * IMG_DIM;
    localparam int IW   = $clog2(NPIX);
    localparam int CW   = $clog2(IMG_DIM);

    // Address stepping constants; the grid walk uses only adds.
    localparam logic [FB_AW-1:0] BASE0    = FB_AW'(Y0 * FRAME_W + X0);
    localparam logic [FB_AW-1:0] ROW_STEP = FB_AW'(STRIDE * FRAME_W);
    localparam logic [FB_AW-1:0] COL_STEP = FB_AW'(STRIDE);
    localparam logic [IW-1:0]    LAST_IDX = IW'(NPIX - 1);
    localparam logic [CW-1:0]    LAST_COL = CW'(IMG_DIM - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_COMMIT
    } state_t;

    state_t state;
    state_t state_nxt;

    // Grid walker: row_base + col_off is the frame address of pixel scan_idx.
    logic [FB_AW-1:0] row_base;
    logic [FB_AW-1:0] col_off;
    logic [CW-1:0]    col_cnt;
    logic [IW-1:0]    scan_idx;

    // Stage 0 is the address on the bus this cycle; stage RD_LAT lines up
    // with the frame-buffer data for that address.
    logic [RD_LAT:0]  vld_pipe;
    logic [IW-1:0]    idx_pipe [0:RD_LAT];

    logic [NPIX-1:0]  shadow;
    logic [9:0]       shadow_cnt;
    logic [NPIX-1:0]  image;

    logic             issue_first;
    logic             issue_next;
    logic             cap_vld;
    logic [IW-1:0]    cap_idx;
    logic [5:0]       gray;
    logic             cap_bit;

    assign issue_first = (state == S_IDLE) && start;
    assign issue_next  = (state == S_SCAN) && (scan_idx != LAST_IDX);
    assign cap_vld     = vld_pipe[RD_LAT];
    assign cap_idx     = idx_pipe[RD_LAT];

    // Max gray is 3*15 = 45, fits 6 bits without overflow.
    assign gray    = {2'b00, fb_data[11:8]} + {2'b00, fb_data[7:4]} + {2'b00, fb_data[3:0]};
    assign cap_bit = (gray < threshold) ^ invert;

    // busy is exactly "not idle": rises at the edge that accepts start,
    // falls at the commit edge.
    assign busy = (state != S_IDLE);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_SCAN;
            // scan_idx == LAST_IDX means the final address is already on the bus.
            S_SCAN:   if (scan_idx == LAST_IDX) state_nxt = S_DRAIN;
            S_DRAIN:  if (cap_vld && (cap_idx == LAST_IDX)) state_nxt = S_COMMIT;
            S_COMMIT: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Address generation
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_base <= '0;
            col_off  <= '0;
            col_cnt  <= '0;
            scan_idx <= '0;
            fb_addr  <= '0;
        end else if (issue_first) begin
            row_base <= BASE0;
            col_off  <= '0;
            col_cnt  <= '0;
            scan_idx <= '0;
            fb_addr  <= BASE0;
        end else if (issue_next) begin
            scan_idx <= scan_idx + IW'(1);
            if (col_cnt == LAST_COL) begin
                col_cnt  <= '0;
                col_off  <= '0;
                row_base <= row_base + ROW_STEP;
                fb_addr  <= row_base + ROW_STEP;
            end else begin
                col_cnt  <= col_cnt + CW'(1);
                col_off  <= col_off + COL_STEP;
                fb_addr  <= row_base + col_off + COL_STEP;
            end
        end
        // otherwise fb_addr holds (DRAIN, COMMIT, IDLE)
    end

    // ------------------------------------------------------------------
    // Read-return tagging
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            for (int k = 0; k <= RD_LAT; k++) begin
                idx_pipe[k] <= '0;
            end
        end else begin
            vld_pipe[0] <= issue_first || issue_next;
            idx_pipe[0] <= issue_first ? '0 : (scan_idx + IW'(1));
            for (int k = 1; k <= RD_LAT; k++) begin
                vld_pipe[k] <= vld_pipe[k-1];
                idx_pipe[k] <= idx_pipe[k-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Shadow image and popcount
    // ------------------------------------------------------------------
    // Every shadow bit is rewritten before each commit, so no reset is needed.
    always_ff @(posedge clk) begin
        if (cap_vld) begin
            shadow[cap_idx] <= cap_bit;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow_cnt <= '0;
        end else if (issue_first) begin
            shadow_cnt <= '0;
        end else if (cap_vld && cap_bit) begin
            shadow_cnt <= shadow_cnt + 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Commit and NN read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            image       <= '0;
            dark_count  <= '0;
            image_valid <= 1'b0;
            done        <= 1'b0;
            nn_data     <= 1'b0;
        end else begin
            done <= (state == S_COMMIT);
            if (state == S_COMMIT) begin
                image       <= shadow;
                dark_count  <= shadow_cnt;
                image_valid <= 1'b1;
            end
            // Reads the committed image only, so a capture in flight is never visible.
            if (nn_addr < 16'(NPIX)) begin
                nn_data <= image[nn_addr[IW-1:0]];
            end else begin
                nn_data <= 1'b0;
            end
        end
    end

endmodule
